// File: rtl/combo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : combo_pkg
// Brief    : Shared types and default timing constants for the combo_entry
//            button-driven passcode entry block.
// Revision : 1.0 - initial release
// ============================================================================
package combo_pkg;

  // Default timing, in clk cycles
  localparam int c_DEBOUNCE_DEFAULT = 16;
  localparam int c_SUBMIT_DEFAULT   = 4;
  localparam int c_HOLDOFF_DEFAULT  = 64;

  // Entry sequencer states
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SETUP        = 3'd1,
    ST_STROBE       = 3'd2,
    ST_HOLDOFF      = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } combo_state_t;

  // Bits needed to hold values 0..max_val; never below 1 so a zero-length
  // phase still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/combo_debounce.sv
`default_nettype none
// ============================================================================
// Module   : combo_debounce
// Brief    : Two-flop synchronizer, run-length debouncer and rising-edge
//            detector for a raw mechanical push-button.
// Revision : 1.0 - initial release
// ============================================================================
module combo_debounce
  import combo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press,
  output logic o_level
);

  localparam int              c_CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_level_d;
  logic [c_CW-1:0] r_cnt;

  // Synchronize the raw pin, then accept a new level only after it has
  // differed from the current one for a full unbroken run of cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == c_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        // Any reversion to the accepted level restarts the run
        r_cnt <= '0;
      end
    end
  end

  // One-cycle pulse on the accepted 0->1 transition
  assign o_press = r_level & ~r_level_d;
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/combo_entry.sv
`default_nettype none
// ============================================================================
// Module   : combo_entry
// Brief    : Captures the slide-switch code on a debounced button press and
//            presents it to the lock stage with a setup cycle, a fixed-width
//            submit strobe, a holdoff window and a wait-for-release phase.
//            Optional build macro COMBO_ENTRY_NIBBLE_EN enables two-press
//            entry of the code from sw[3:0] (high nibble first).
// Revision : 1.0 - initial release
// ============================================================================
module combo_entry
  import combo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_DEFAULT,
  parameter int SUBMIT_WIDTH    = c_SUBMIT_DEFAULT,
  parameter int HOLDOFF_CYCLES  = c_HOLDOFF_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_submit,
  input  logic [7:0] sw,
  output logic [7:0] passcode_attempt,
  output logic       submit,
  output logic       busy,
  output logic       nibble_pending
);

  // One shared phase counter serves both STROBE and HOLDOFF
  localparam int c_CNT_MAX = (SUBMIT_WIDTH > HOLDOFF_CYCLES) ? SUBMIT_WIDTH
                                                             : HOLDOFF_CYCLES;
  localparam int              c_CW        = cnt_width(c_CNT_MAX);
  localparam logic [c_CW-1:0] c_SUB_LAST  = c_CW'(SUBMIT_WIDTH - 1);
  localparam logic [c_CW-1:0] c_HOLD_LAST =
      c_CW'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

  logic [7:0]      r_sw_s1;
  logic [7:0]      r_sw_s2;
  logic            w_press;
  logic            w_level;

  combo_state_t    r_state;
  combo_state_t    w_next;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_next;
  logic [7:0]      r_code;
  logic [7:0]      w_code_next;
  logic            r_submit;
  logic            r_busy;

`ifdef COMBO_ENTRY_NIBBLE_EN
  logic [3:0]      r_nib_hi;
  logic [3:0]      w_nib_hi_next;
  logic            r_nib_pending;
  logic            w_nib_pending_next;
  logic [3:0]      w_unused_sw_hi;

  // Only the low nibble of the switches is consumed in this mode
  assign w_unused_sw_hi = r_sw_s2[7:4];
`endif

  // Button synchronizer, debouncer and press detector
  combo_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_submit),
    .o_press (w_press),
    .o_level (w_level)
  );

  // Two-flop synchronizer for the slide switches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_s1 <= 8'h00;
      r_sw_s2 <= 8'h00;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Next-state, phase counter and capture decisions
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = '0;
    w_code_next = r_code;
`ifdef COMBO_ENTRY_NIBBLE_EN
    w_nib_hi_next      = r_nib_hi;
    w_nib_pending_next = r_nib_pending;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_press) begin
`ifdef COMBO_ENTRY_NIBBLE_EN
          if (!r_nib_pending) begin
            // First press only stages the high nibble; no strobe follows
            w_nib_hi_next      = r_sw_s2[3:0];
            w_nib_pending_next = 1'b1;
            w_next             = ST_WAIT_RELEASE;
          end else begin
            w_code_next        = {r_nib_hi, r_sw_s2[3:0]};
            w_nib_pending_next = 1'b0;
            w_next             = ST_SETUP;
          end
`else
          w_code_next = r_sw_s2;
          w_next      = ST_SETUP;
`endif
        end
      end
      ST_SETUP: begin
        // Data already stable on passcode_attempt; strobe rises next cycle
        w_next = ST_STROBE;
      end
      ST_STROBE: begin
        if (r_cnt == c_SUB_LAST) begin
          w_next = (HOLDOFF_CYCLES == 0) ? ST_WAIT_RELEASE : ST_HOLDOFF;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_next = ST_WAIT_RELEASE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!w_level) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, counter and captured code registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_code  <= 8'h00;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_code  <= w_code_next;
    end
  end

  // Outputs registered from the next state so they change cleanly on clk
  always_ff @(posedge clk) begin
    if (rst) begin
      r_submit <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_submit <= (w_next == ST_STROBE);
      r_busy   <= (w_next != ST_IDLE);
    end
  end

`ifdef COMBO_ENTRY_NIBBLE_EN
  // Staged high nibble survives until consumed or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nib_hi      <= 4'h0;
      r_nib_pending <= 1'b0;
    end else begin
      r_nib_hi      <= w_nib_hi_next;
      r_nib_pending <= w_nib_pending_next;
    end
  end

  assign nibble_pending = r_nib_pending;
`else
  assign nibble_pending = 1'b0;
`endif

  assign passcode_attempt = r_code;
  assign submit           = r_submit;
  assign busy             = r_busy;

endmodule
`default_nettype wire
